// File: rtl/noc_rx_decoder.sv
// Receive endpoint of the swarm NoC: decodes router flits into a divergence
// holding register, an LBD-filtered clause FIFO and a per-core status table.
package noc_pkg;
   localparam int CORE_ID_W = 4;
   localparam int LBD_W     = 8;
   localparam int VC_W      = 2;

   typedef enum logic [1:0] {
      MSG_DIVERGE = 2'b00,
      MSG_CLAUSE  = 2'b01,
      MSG_STATUS  = 2'b10,
      MSG_UNDEF   = 2'b11
   } msg_type_e;

   // 2 + 4 + 2 + 8 + 64 = 80 bits
   typedef struct packed {
      msg_type_e              msg_type;
      logic [CORE_ID_W-1:0]   src_id;
      logic [VC_W-1:0]        virtual_channel;
      logic [LBD_W-1:0]       quality_metric;
      logic [63:0]            payload;
   } noc_packet_t;
endpackage

module noc_rx_decoder
   import noc_pkg::*;
#(
   parameter logic [CORE_ID_W-1:0] CORE_ID   = '0,
   parameter int                   CLS_DEPTH = 4,
   parameter int                   LBD_MAX   = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  noc_packet_t                 in_pkt,
   output logic                        div_valid,
   input  logic                        div_ready,
   output logic [31:0]                 div_lit,
   output logic                        cls_valid,
   input  logic                        cls_ready,
   output logic [31:0]                 cls_lit0,
   output logic [31:0]                 cls_lit1,
   output logic [LBD_W-1:0]            cls_lbd,
   output logic [CORE_ID_W-1:0]        cls_src,
   output logic [2*(2**CORE_ID_W)-1:0] peer_status,
   output logic [15:0]                 drop_cnt
);

   localparam int                PTR_W     = $clog2(CLS_DEPTH);
   localparam int                STAT_W    = 2 * (2**CORE_ID_W);
   localparam logic [LBD_W-1:0]  LBD_MAX_C = LBD_W'(LBD_MAX);
   localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W+1)'(CLS_DEPTH);

   typedef struct packed {
      logic [31:0]          lit0;
      logic [31:0]          lit1;
      logic [LBD_W-1:0]     lbd;
      logic [CORE_ID_W-1:0] src;
   } cls_entry_t;

   logic              div_full_q, div_full_d;
   logic [31:0]       div_lit_q, div_lit_d;
   cls_entry_t        cls_mem_q [CLS_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    cnt_q, cnt_d;
   logic [STAT_W-1:0] peer_q, peer_d;
   logic [15:0]       drop_q, drop_d;

   logic       acc, foreign, cls_full, cls_ok;
   logic       is_div, is_cls, is_stat, is_undef;
   logic       push, pop, drop;
   cls_entry_t push_entry;

   // The router has already arbitrated virtual channels.
   logic unused_vc;
   assign unused_vc = ^in_pkt.virtual_channel;

   assign cls_full = (cnt_q == DEPTH_C);

   always_comb begin
      in_ready = rst_n;
      case (in_pkt.msg_type)
         MSG_DIVERGE: if (div_full_q) in_ready = 1'b0;
         MSG_CLAUSE:  if (cls_full)   in_ready = 1'b0;
         default:     ;
      endcase
   end

   assign acc      = in_valid & in_ready;
   assign foreign  = (in_pkt.src_id != CORE_ID);
   assign is_div   = acc & foreign & (in_pkt.msg_type == MSG_DIVERGE);
   assign is_cls   = acc & foreign & (in_pkt.msg_type == MSG_CLAUSE);
   assign is_stat  = acc & foreign & (in_pkt.msg_type == MSG_STATUS);
   assign is_undef = acc & foreign & (in_pkt.msg_type == MSG_UNDEF);
   assign cls_ok   = (in_pkt.quality_metric <= LBD_MAX_C);
   assign push     = is_cls & cls_ok;
   assign pop      = (cnt_q != '0) & cls_ready;
   assign drop     = (is_cls & ~cls_ok) | is_undef;

   assign push_entry = '{lit0: in_pkt.payload[63:32],
                         lit1: in_pkt.payload[31:0],
                         lbd:  in_pkt.quality_metric,
                         src:  in_pkt.src_id};

   always_comb begin
      div_full_d = div_full_q;
      div_lit_d  = div_lit_q;
      if (div_full_q && div_ready) div_full_d = 1'b0;
      if (is_div) begin
         div_full_d = 1'b1;
         div_lit_d  = in_pkt.payload[31:0];
      end

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: ;
      endcase

      peer_d = peer_q;
      if (is_stat) peer_d[{in_pkt.src_id, 1'b0} +: 2] = in_pkt.payload[1:0];

      drop_d = drop_q;
      if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_full_q <= 1'b0;
         div_lit_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         peer_q     <= '0;
         drop_q     <= '0;
         for (int i = 0; i < CLS_DEPTH; i++) cls_mem_q[i] <= '0;
      end else begin
         div_full_q <= div_full_d;
         div_lit_q  <= div_lit_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         peer_q     <= peer_d;
         drop_q     <= drop_d;
         if (push) cls_mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign div_valid   = div_full_q;
   assign div_lit     = div_lit_q;
   assign cls_valid   = (cnt_q != '0);
   assign cls_lit0    = cls_mem_q[rd_ptr_q].lit0;
   assign cls_lit1    = cls_mem_q[rd_ptr_q].lit1;
   assign cls_lbd     = cls_mem_q[rd_ptr_q].lbd;
   assign cls_src     = cls_mem_q[rd_ptr_q].src;
   assign peer_status = peer_q;
   assign drop_cnt    = drop_q;

endmodule

// File: doc/noc_rx_decoder.md
# noc_rx_decoder

Receive-side endpoint of the swarm NoC inside each solver core. It accepts `noc_packet_t` flits from the local router port over a valid/ready handshake and decodes them by `msg_type`. Divergence literals go to a one-entry holding register, shared learned clauses go to a small FIFO after an LBD quality filter, and peer status codes go to a per-core status table. It is the consumer-side counterpart of the core's packet encoder and sits between the router and the CDCL controller.

## Interface
- `CORE_ID`, 0: this core's ID (`CORE_ID_W` bits). Packets whose `src_id` equals it are discarded.
- `CLS_DEPTH`, 4: clause FIFO depth; power of 2, ≥2.
- `LBD_MAX`, 8: clauses with `quality_metric > LBD_MAX` are discarded.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input flit valid.
- `in_ready` out 1: input flit accepted this cycle when high together with `in_valid`.
- `in_pkt` in `$bits(noc_packet_t)` (80): incoming packet.
- `div_valid` out 1, `div_ready` in 1: divergence output handshake.
- `div_lit` out 32: `payload[31:0]` of the held divergence packet.
- `cls_valid` out 1, `cls_ready` in 1: clause output handshake, driven from the FIFO head.
- `cls_lit0` out 32, `cls_lit1` out 32: `payload[63:32]` and `payload[31:0]` respectively.
- `cls_lbd` out `LBD_W`, `cls_src` out `CORE_ID_W`: quality metric and originating core.
- `peer_status` out `2*2**CORE_ID_W`: 2-bit state per core; core k occupies bits `[2k+1:2k]`.
- `drop_cnt` out 16: saturating count of discarded packets.

## Operation
- Accept: `acc = in_valid & in_ready`. The sender must hold `in_pkt` stable while `in_valid & !in_ready`.
- `in_ready` is combinational and is 0 while `rst_n` is low. Otherwise it is 1 except in these two cases:
  - `msg_type==MSG_DIVERGE` and the divergence register is full.
  - `msg_type==MSG_CLAUSE` and the FIFO is full. The full check ignores a same-cycle pop; there is no bypass.
- Self-filter: an accepted packet with `src_id==CORE_ID` (any type) is consumed with no side effects. `drop_cnt` does not change.
- `MSG_DIVERGE`: loads the one-entry register and sets `div_valid`. The register clears on `div_valid & div_ready`.
  - Load and clear in the same cycle cannot occur, because `in_ready` is low whenever the register is full.
- `MSG_CLAUSE`:
  - If `quality_metric > LBD_MAX`, consume the packet and increment `drop_cnt`.
  - Otherwise push {lit0, lit1, lbd, src} into the FIFO.
  - The FIFO uses wrapping read/write pointers of `$clog2(CLS_DEPTH)` bits and a count of `$clog2(CLS_DEPTH)+1` bits.
  - Push and pop in the same cycle leave the count unchanged.
- `MSG_STATUS`: write `payload[1:0]` into the `peer_status` slot for `src_id`. Always accepted; the last write wins.
- Encoding 2'b11 (undefined): consume the packet and increment `drop_cnt`.
- `drop_cnt` saturates at 16'hFFFF and never wraps.
- `virtual_channel` is ignored by this block; the router has already arbitrated VCs.

## Timing
- Reset values: `div_valid=0`, `cls_valid=0`, `div_lit=0`, `cls_*=0`, `peer_status=0`, `drop_cnt=0`, FIFO empty, `in_ready=0`.
- All outputs except `in_ready` are registered.
- Latency:
  - A divergence or clause accepted at edge N is presented with valid high in cycle N+1.
  - A status written at edge N is visible in `peer_status` in cycle N+1.
  - A `drop_cnt` increment at edge N is visible in cycle N+1.
- Throughput: one flit per cycle while buffers have space. A full FIFO with `cls_ready=1` sustains one clause per cycle after a 1-cycle bubble.
- Output valids never drop without their ready. Output data is stable while valid is high and ready is low.
- Asserting `rst_n` low mid-transfer empties all buffers immediately and loses any in-flight entries; this is not an error.

## Test plan
- Reset, then send DIVERGE with src=1 and payload[31:0]=32'hFFFF_FFF9 (-7) at N → `div_lit=-7` and `div_valid=1` at N+1. A second DIVERGE stalls with `in_ready=0` until `div_ready` is pulsed.
- Push 5 clauses with LBD=3 and `cls_ready=0`, `CLS_DEPTH=4` → 4 accepted; `in_ready=0` on the 5th. Release `cls_ready` → clauses emerge in FIFO order with correct lit0/lit1/src.
- Send a CLAUSE with `quality_metric=9` and `LBD_MAX=8` → consumed, no `cls_valid`, `drop_cnt=1`. A CLAUSE with LBD=8 is enqueued.
- Send a STATUS from src=3 with payload=2'b10, then a STATUS from src=3 with payload=2'b01 → `peer_status[7:6]=2'b10` then `2'b01`, one cycle after each accept.
- Send a DIVERGE with src=`CORE_ID` and a packet with type 2'b11 → the first has no effect; the second gives `drop_cnt+1`. Preload `drop_cnt` to 16'hFFFF → it stays at 16'hFFFF.
- Assert `rst_n` low while the FIFO holds 3 clauses → `cls_valid=0`, `in_ready=0` and `peer_status=0` immediately. After release, the FIFO is empty.
